// File: rtl/sat_ctrl_pkg.sv
// Shared definitions for the bin scheduler: widths, FSM states, core result
// encoding, and a saturating counter helper.
package sat_ctrl_pkg;

  localparam int WIDTH_BIN_ID = 10;
  localparam int WIDTH_LVL    = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_UPDATE,
    ST_BKT,
    ST_DONE_SAT,
    ST_DONE_UNSAT
  } sched_state_e;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_SAT,
    RES_UNSAT
  } result_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ctrl_bin_sched_pulse_edge.sv
// Rising-edge detector. With REG_OUT=1 the rise is registered, giving a
// clean one-cycle pulse one cycle after sig_i goes high (used for the
// start_* strobes). With REG_OUT=0 the rise is combinational, so a caller
// can capture side-band data in the same cycle as the edge.
module pulse_edge #(
  parameter bit REG_OUT = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic edge_o
);

  logic prev_q;
  logic rise;

  assign rise = sig_i & ~prev_q;

  // Remember last cycle's level of sig_i.
  always_ff @(posedge clk) begin
    if (!rst) prev_q <= 1'b0;
    else      prev_q <= sig_i;
  end

  generate
    if (REG_OUT) begin : g_reg
      logic pulse_q;
      // Register the rise so the pulse is a flop output.
      always_ff @(posedge clk) begin
        if (!rst) pulse_q <= 1'b0;
        else      pulse_q <= rise;
      end
      assign edge_o = pulse_q;
    end else begin : g_comb
      assign edge_o = rise;
    end
  endgenerate

endmodule

// File: rtl/ctrl_bin_sched.sv
// Bin scheduler: walks bins 0..bin_total-1 through load -> core run ->
// write-back, advancing on partial SAT and backtracking on partial UNSAT,
// and reports global SAT/UNSAT.
// Optional statistics counters are enabled by defining CTRL_BIN_SCHED_STAT_EN.
module ctrl_bin_sched
  import sat_ctrl_pkg::*;
#(
  parameter int WIDTH_BIN_ID = sat_ctrl_pkg::WIDTH_BIN_ID,
  parameter int WIDTH_LVL    = sat_ctrl_pkg::WIDTH_LVL
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [WIDTH_BIN_ID-1:0] bin_total_i,
  output logic                    done_o,
  output logic                    global_sat_o,
  output logic                    global_unsat_o,
  output logic                    start_load_o,
  output logic [WIDTH_BIN_ID-1:0] load_bin_id_o,
  input  logic                    done_load_i,
  output logic                    start_core_o,
  input  logic                    done_core_i,
  input  logic                    core_sat_i,
  input  logic                    core_unsat_i,
  input  logic [WIDTH_BIN_ID-1:0] bkt_bin_num_i,
  input  logic [WIDTH_LVL-1:0]    bkt_lvl_i,
  output logic                    start_update_o,
  input  logic                    done_update_i,
  output logic                    start_bkt_o,
  output logic [WIDTH_BIN_ID-1:0] bkt_bin_num_o,
  input  logic                    done_bkt_i,
`ifdef CTRL_BIN_SCHED_STAT_EN
  output logic [31:0]             stat_core_runs_o,
  output logic [31:0]             stat_bkts_o,
`endif
  output logic [WIDTH_BIN_ID-1:0] cur_bin_num_o
);

  sched_state_e            state_q;
  result_e                 res_q, res_d;
  logic [WIDTH_BIN_ID-1:0] cur_bin_q;
  logic [WIDTH_BIN_ID-1:0] bkt_bin_q, bkt_tgt_d;
  logic [WIDTH_LVL-1:0]    bkt_lvl_q, bkt_lvl_d;
  logic [WIDTH_BIN_ID-1:0] last_bin;
  logic                    done_q, gsat_q, gunsat_q;
  logic                    armed_q;
  logic                    core_rise;

  // One-shot strobes fire one cycle after entering their owning state.
  pulse_edge #(.REG_OUT(1'b1)) u_pls_load (
    .clk(clk), .rst(rst), .sig_i(state_q == ST_LOAD),   .edge_o(start_load_o));
  pulse_edge #(.REG_OUT(1'b1)) u_pls_core (
    .clk(clk), .rst(rst), .sig_i(state_q == ST_RUN),    .edge_o(start_core_o));
  pulse_edge #(.REG_OUT(1'b1)) u_pls_upd (
    .clk(clk), .rst(rst), .sig_i(state_q == ST_UPDATE), .edge_o(start_update_o));
  pulse_edge #(.REG_OUT(1'b1)) u_pls_bkt (
    .clk(clk), .rst(rst), .sig_i(state_q == ST_BKT),    .edge_o(start_bkt_o));

  // done_core_i is a level; only a fresh 0->1 after start_core_o counts.
  pulse_edge #(.REG_OUT(1'b0)) u_core_edge (
    .clk(clk), .rst(rst), .sig_i(done_core_i), .edge_o(core_rise));

  assign last_bin = bin_total_i - WIDTH_BIN_ID'(1);

  // Decode the core result: unsat wins a tie, no result is a fail-safe
  // unsat at level 0, and a backtrack target above cur_bin is clamped.
  always_comb begin
    res_d     = RES_UNSAT;
    bkt_lvl_d = bkt_lvl_i;
    bkt_tgt_d = (bkt_bin_num_i > cur_bin_q) ? cur_bin_q : bkt_bin_num_i;
    if (!core_unsat_i && core_sat_i) begin
      res_d = RES_SAT;
    end else if (!core_unsat_i && !core_sat_i) begin
      bkt_lvl_d = '0;
    end
  end

  // Main scheduler FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      res_q     <= RES_NONE;
      cur_bin_q <= '0;
      bkt_bin_q <= '0;
      bkt_lvl_q <= '0;
      done_q    <= 1'b0;
      gsat_q    <= 1'b0;
      gunsat_q  <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            cur_bin_q <= '0;
            done_q    <= 1'b0;
            gsat_q    <= 1'b0;
            gunsat_q  <= 1'b0;
            state_q   <= (bin_total_i == '0) ? ST_DONE_UNSAT : ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (done_load_i) state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (start_core_o) armed_q <= 1'b1;
          if (armed_q && core_rise) begin
            res_q     <= res_d;
            bkt_bin_q <= bkt_tgt_d;
            bkt_lvl_q <= bkt_lvl_d;
            armed_q   <= 1'b0;
            state_q   <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          if (done_update_i) begin
            if (res_q == RES_SAT) begin
              if (cur_bin_q == last_bin) begin
                state_q <= ST_DONE_SAT;
              end else begin
                cur_bin_q <= cur_bin_q + WIDTH_BIN_ID'(1);
                state_q   <= ST_LOAD;
              end
            end else if (bkt_lvl_q == '0) begin
              state_q <= ST_DONE_UNSAT;
            end else begin
              state_q <= ST_BKT;
            end
          end
        end
        ST_BKT: begin
          if (done_bkt_i) begin
            cur_bin_q <= bkt_bin_q;
            state_q   <= ST_LOAD;
          end
        end
        ST_DONE_SAT: begin
          gsat_q  <= 1'b1;
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        ST_DONE_UNSAT: begin
          gunsat_q <= 1'b1;
          done_q   <= 1'b1;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign done_o         = done_q;
  assign global_sat_o   = gsat_q;
  assign global_unsat_o = gunsat_q;
  assign load_bin_id_o  = cur_bin_q;
  assign bkt_bin_num_o  = bkt_bin_q;
  assign cur_bin_num_o  = cur_bin_q;

`ifdef CTRL_BIN_SCHED_STAT_EN
  logic [31:0] runs_q, bkts_q;

  // Saturating run/backtrack counters, cleared when a new problem starts.
  always_ff @(posedge clk) begin
    if (!rst) begin
      runs_q <= '0;
      bkts_q <= '0;
    end else if (state_q == ST_IDLE && start_i) begin
      runs_q <= '0;
      bkts_q <= '0;
    end else begin
      if (start_core_o) runs_q <= sat_inc32(runs_q);
      if (start_bkt_o)  bkts_q <= sat_inc32(bkts_q);
    end
  end

  assign stat_core_runs_o = runs_q;
  assign stat_bkts_o      = bkts_q;
`endif

endmodule

// File: tb/tb_ctrl_bin_sched.sv
// Scoreboard bench for ctrl_bin_sched: scenarios push expected load /
// backtrack / done events; a monitor pops and compares as the DUT emits them.
module tb_ctrl_bin_sched;
  localparam int BW = 10;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start_i = 1'b0;
  logic [BW-1:0] bin_total_i = '0;
  logic          done_o, global_sat_o, global_unsat_o;
  logic          start_load_o, start_core_o, start_update_o, start_bkt_o;
  logic [BW-1:0] load_bin_id_o, bkt_bin_num_o, cur_bin_num_o;
  logic          done_load_i = 1'b0, done_core_i = 1'b0, done_update_i = 1'b0, done_bkt_i = 1'b0;
  logic          core_sat_i = 1'b0, core_unsat_i = 1'b0;
  logic [BW-1:0] bkt_bin_num_i = '0;
  logic [LW-1:0] bkt_lvl_i = '0;
`ifdef CTRL_BIN_SCHED_STAT_EN
  logic [31:0]   stat_core_runs_o, stat_bkts_o;
`endif

  ctrl_bin_sched dut (
    .clk(clk), .rst(rst), .start_i(start_i), .bin_total_i(bin_total_i),
    .done_o(done_o), .global_sat_o(global_sat_o), .global_unsat_o(global_unsat_o),
    .start_load_o(start_load_o), .load_bin_id_o(load_bin_id_o), .done_load_i(done_load_i),
    .start_core_o(start_core_o), .done_core_i(done_core_i), .core_sat_i(core_sat_i),
    .core_unsat_i(core_unsat_i), .bkt_bin_num_i(bkt_bin_num_i), .bkt_lvl_i(bkt_lvl_i),
    .start_update_o(start_update_o), .done_update_i(done_update_i),
    .start_bkt_o(start_bkt_o), .bkt_bin_num_o(bkt_bin_num_o), .done_bkt_i(done_bkt_i),
`ifdef CTRL_BIN_SCHED_STAT_EN
    .stat_core_runs_o(stat_core_runs_o), .stat_bkts_o(stat_bkts_o),
`endif
    .cur_bin_num_o(cur_bin_num_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit sat; bit unsat; int bbin; int blvl; bit stale; bit hold;
  } core_t;

  // Events: 10000+bin = load, 20000+bin = backtrack,
  // 30000 + cur*4 + sat*2 + unsat = done.
  int    exp_q[$];
  core_t core_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  bit    upd_stall = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  task automatic pop_cmp(input string name, input int act);
    if (exp_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: unexpected event %0d, scoreboard empty", name, act);
    end else begin
      check(name, act, exp_q.pop_front());
    end
  endtask

  function automatic void push_load(input int b);  exp_q.push_back(10000 + b); endfunction
  function automatic void push_bkt(input int b);   exp_q.push_back(20000 + b); endfunction
  function automatic void push_done(input int cur, input int s, input int u);
    exp_q.push_back(30000 + cur*4 + s*2 + u);
  endfunction
  function automatic void push_core(input bit s, input bit u, input int bb, input int bl,
                                    input bit stale, input bit hold);
    core_t c;
    c.sat = s; c.unsat = u; c.bbin = bb; c.blvl = bl; c.stale = stale; c.hold = hold;
    core_q.push_back(c);
  endfunction

  // Monitor: compare every emitted event against the scoreboard.
  initial begin
    logic done_prev;
    done_prev = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (start_load_o) pop_cmp("load", 10000 + int'(load_bin_id_o));
      if (start_bkt_o)  pop_cmp("bkt",  20000 + int'(bkt_bin_num_o));
      if (done_o && !done_prev)
        pop_cmp("done", 30000 + int'(cur_bin_num_o)*4 + int'(global_sat_o)*2 + int'(global_unsat_o));
      done_prev = done_o;
    end
  end

  // Engine models answering the start_* strobes.
  initial forever begin
    @(posedge clk); #1;
    if (start_load_o) begin
      repeat (2) @(posedge clk); #1; done_load_i = 1'b1;
      @(posedge clk); #1; done_load_i = 1'b0;
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (start_update_o && !upd_stall) begin
      repeat (2) @(posedge clk); #1; done_update_i = 1'b1;
      @(posedge clk); #1; done_update_i = 1'b0;
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (start_bkt_o) begin
      repeat (3) @(posedge clk); #1; done_bkt_i = 1'b1;
      @(posedge clk); #1; done_bkt_i = 1'b0;
    end
  end

  // Core model: stale mode keeps the old high level (with misleading sat
  // data) for a while, drops it, then rises with the real result.
  initial begin
    core_t c;
    forever begin
      @(posedge clk); #1;
      if (start_core_o) begin
        if (core_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL core_underrun: got extra start_core_o, want none");
          c.sat = 1'b1; c.unsat = 1'b0; c.bbin = 0; c.blvl = 0; c.stale = 1'b0; c.hold = 1'b0;
        end else begin
          c = core_q.pop_front();
        end
        if (c.stale) begin
          core_sat_i = 1'b1; core_unsat_i = 1'b0;
          repeat (4) @(posedge clk); #1; done_core_i = 1'b0;
          @(posedge clk); #1;
        end else begin
          repeat (2) @(posedge clk); #1;
        end
        core_sat_i    = c.sat;
        core_unsat_i  = c.unsat;
        bkt_bin_num_i = BW'(c.bbin);
        bkt_lvl_i     = LW'(c.blvl);
        done_core_i   = 1'b1;
        if (!c.hold) begin
          repeat (2) @(posedge clk); #1; done_core_i = 1'b0;
        end
      end
    end
  end

  task automatic run_scn(input string name, input int total);
    int cyc;
    bin_total_i = BW'(total);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    cyc = 0;
    while (!done_o && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!done_o) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: got no done_o in %0d cycles, want done_o", name, cyc);
    end
    repeat (4) @(posedge clk); #1;
    check({name, "_sticky"},    int'(done_o), 1);
    check({name, "_exp_left"},  exp_q.size(), 0);
    check({name, "_core_left"}, core_q.size(), 0);
    exp_q.delete();
    core_q.delete();
  endtask

  task automatic check_idle_outs(input string name);
    check({name, "_strobes"}, int'({start_load_o, start_core_o, start_update_o, start_bkt_o,
                                     done_o, global_sat_o, global_unsat_o}), 0);
    check({name, "_load_id"}, int'(load_bin_id_o), 0);
    check({name, "_bkt_bin"}, int'(bkt_bin_num_o), 0);
    check({name, "_cur_bin"}, int'(cur_bin_num_o), 0);
  endtask

  initial begin
    int cyc;
    rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    check_idle_outs("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    // All sat over three bins.
    push_load(0); push_load(1); push_load(2); push_done(2, 1, 0);
    repeat (3) push_core(1, 0, 0, 0, 0, 0);
    run_scn("allsat3", 3);

    // Unsat at bin 2 backtracks to bin 1, then all sat.
    push_load(0); push_load(1); push_load(2); push_bkt(1);
    push_load(1); push_load(2); push_load(3); push_done(3, 1, 0);
    push_core(1, 0, 0, 0, 0, 0); push_core(1, 0, 0, 0, 0, 0);
    push_core(0, 1, 1, 5, 0, 0);
    repeat (3) push_core(1, 0, 0, 0, 0, 0);
    run_scn("bkt4", 4);
`ifdef CTRL_BIN_SCHED_STAT_EN
    check("stat_runs", int'(stat_core_runs_o), 6);
    check("stat_bkts", int'(stat_bkts_o), 1);
`endif

    // Unsat at level 0 ends the run immediately.
    push_load(0); push_done(0, 0, 1);
    push_core(0, 1, 0, 0, 0, 0);
    run_scn("unsat_lvl0", 2);

    // Stale high done_core with sat data must be ignored; real result has
    // both sat and unsat high, which resolves to unsat at level 0.
    push_load(0); push_load(1); push_done(1, 0, 1);
    push_core(1, 0, 0, 0, 0, 1);
    push_core(1, 1, 0, 0, 1, 0);
    run_scn("stale_tie", 2);

    // Backtrack target above cur_bin clamps to cur_bin.
    push_load(0); push_load(1); push_bkt(1); push_load(1); push_load(2); push_done(2, 1, 0);
    push_core(1, 0, 0, 0, 0, 0); push_core(0, 1, 7, 3, 0, 0);
    push_core(1, 0, 0, 0, 0, 0); push_core(1, 0, 0, 0, 0, 0);
    run_scn("clamp", 3);

    // Neither sat nor unsat: fail-safe global unsat.
    push_load(0); push_done(0, 0, 1);
    push_core(0, 0, 1, 9, 0, 0);
    run_scn("noresult", 2);

    // Single bin.
    push_load(0); push_done(0, 1, 0);
    push_core(1, 0, 0, 0, 0, 0);
    run_scn("onebin", 1);

    // Zero bins: straight to unsat.
    push_done(0, 0, 1);
    run_scn("zerobin", 0);

    // Reset while waiting for write-back.
    upd_stall = 1'b1;
    push_load(0);
    push_core(1, 0, 0, 0, 0, 0);
    bin_total_i = BW'(3);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    cyc = 0;
    while (!start_update_o && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("rst_reach_update", int'(start_update_o), 1);
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_idle_outs("midreset");
    rst = 1'b1;
    upd_stall = 1'b0;
    check("midreset_exp_left", exp_q.size(), 0);
    exp_q.delete();
    core_q.delete();
    // A late write-back completion must not wake the idle scheduler.
    done_update_i = 1'b1;
    @(posedge clk); #1;
    done_update_i = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("late_done_strobes", int'({start_load_o, start_core_o, start_update_o, start_bkt_o, done_o}), 0);

    // Restart from bin 0 after the reset.
    push_load(0); push_load(1); push_load(2); push_done(2, 1, 0);
    repeat (3) push_core(1, 0, 0, 0, 0, 0);
    run_scn("restart", 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ctrl_bin_sched.md
Name: ctrl_bin_sched

Overview:
- Top-level bin scheduler that sits directly upstream of the per-bin SAT core controller.
- Walks the bin sequence 0..bin_total-1 and, for each bin, drives load -> core run -> write-back.
- On a partial SAT it advances to the next bin; on a partial UNSAT it backtracks to the bin the core reports.
- Reports global SAT or UNSAT to the host.

Parameters:
- WIDTH_BIN_ID, 10: bin index width.
- WIDTH_LVL, 16: decision-level width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- start_i  in  1  host start; sampled only in IDLE
- bin_total_i  in  WIDTH_BIN_ID  number of bins; 0 is illegal
- done_o  out  1  sticky done; cleared by start_i
- global_sat_o  out  1  sticky; problem is SAT
- global_unsat_o  out  1  sticky; problem is UNSAT
- start_load_o  out  1  1-cycle pulse; load bin load_bin_id_o into engine
- load_bin_id_o  out  WIDTH_BIN_ID  bin to load; held stable from pulse until done_load_i
- done_load_i  in  1  1-cycle pulse; load complete
- start_core_o  out  1  1-cycle pulse to core controller
- done_core_i  in  1  core done level; only its 0->1 edge is used
- core_sat_i  in  1  partial-SAT result
- core_unsat_i  in  1  partial-UNSAT result
- bkt_bin_num_i  in  WIDTH_BIN_ID  backtrack target bin from conflict analysis
- bkt_lvl_i  in  WIDTH_LVL  backtrack level from conflict analysis
- start_update_o  out  1  1-cycle pulse; write bin state back to global memory
- done_update_i  in  1  1-cycle pulse; write-back complete
- start_bkt_o  out  1  1-cycle pulse; undo global assignments above bkt_bin_num_o
- bkt_bin_num_o  out  WIDTH_BIN_ID  registered backtrack target
- done_bkt_i  in  1  1-cycle pulse; global backtrack complete
- cur_bin_num_o  out  WIDTH_BIN_ID  current bin index

Behaviour:
- Reset: all outputs 0, state IDLE, cur_bin 0. Reset mid-operation aborts immediately. Pending done_* inputs are ignored after reset.
- All pulse outputs are registered: asserted exactly 1 cycle, in the cycle after entry to the owning state.
- Waiting states never time out.
- States and transitions:
  - IDLE: on start_i, cur_bin<=0, done_o<=0, global flags<=0 -> LOAD.
  - LOAD: pulse start_load_o with load_bin_id_o=cur_bin; on done_load_i -> RUN.
  - RUN: pulse start_core_o. Arm the edge detector on done_core_i, with the previous value captured at pulse time, so a stale high level is not taken as completion. On a done_core_i rise, capture core_sat_i, core_unsat_i, bkt_bin_num_i and bkt_lvl_i in the same cycle -> UPDATE.
  - UPDATE: pulse start_update_o; wait for done_update_i, then branch:
    - sat captured and cur_bin==bin_total_i-1 -> DONE_SAT.
    - sat captured otherwise: cur_bin<=cur_bin+1 -> LOAD.
    - unsat captured and bkt_lvl==0 -> DONE_UNSAT.
    - unsat captured otherwise -> BKT.
  - BKT: pulse start_bkt_o with bkt_bin_num_o=captured target; on done_bkt_i, cur_bin<=target -> LOAD.
  - DONE_SAT / DONE_UNSAT: set global_sat_o / global_unsat_o and done_o for 1 cycle of the state -> IDLE. Flags stay sticky until the next start_i.
- Result priority: if both core_sat_i and core_unsat_i are high at the capture edge, unsat wins.
- If neither is high at the capture edge: treated as unsat with bkt_lvl 0, so the run ends in global UNSAT (fail-safe).
- Backtrack target rule: a target greater than cur_bin is clamped to cur_bin.
- Single-bin problem: bin_total_i==1 goes to DONE_SAT on the first sat.
- bin_total_i==0: start_i goes straight to DONE_UNSAT.
- Increment never wraps, because the last-bin check precedes the increment.
- start_i is ignored outside IDLE.
- Input pulses arriving in a state that does not wait for them are dropped.

Optional Feature:
- Macro CTRL_BIN_SCHED_STAT_EN.
- Defined: adds outputs stat_core_runs_o[31:0] and stat_bkts_o[31:0]. Each is cleared on start_i. stat_core_runs_o increments on every start_core_o pulse; stat_bkts_o increments on every start_bkt_o pulse. Both saturate at all-ones.
- Undefined: the ports and counters do not exist. FSM timing is identical either way.

Decomposition:
- Shared package sat_ctrl_pkg holds:
  - state encodings for this block;
  - the widths WIDTH_BIN_ID and WIDTH_LVL as localparams;
  - a result enum {RES_NONE, RES_SAT, RES_UNSAT}.
- One natural sub-module, pulse_edge: rising-edge detector plus one-shot generator. It is used for the done_core_i edge and all start_* pulses.

Test Plan:
- bin_total=3, core returns sat on each run -> 3 load/core/update cycles, load_bin_id 0,1,2, global_sat_o=1, done_o=1, no start_bkt_o.
- bin_total=4, bin 2 returns unsat with bkt_bin=1, bkt_lvl=5, then all sat -> one start_bkt_o with bkt_bin_num_o=1, loads 0,1,2,1,2,3, global_sat_o=1.
- bin_total=2, bin 0 returns unsat with bkt_lvl=0 -> global_unsat_o=1 after update, no start_bkt_o, cur_bin_num_o=0.
- done_core_i held high from the prior run at start_core_o -> no capture until it drops and rises again; sat and unsat both high -> treated as unsat.
- Reset asserted while waiting for done_update_i -> next cycle all outputs 0, state IDLE; later start_i restarts from bin 0.
- With CTRL_BIN_SCHED_STAT_EN, scenario 2 -> stat_core_runs_o=6, stat_bkts_o=1.
